// File: rtl/ins_mem_loader_if.sv
// ins_mem_loader_if -- bundle of the host-side load handshake and the
// instruction-memory write port of the instruction memory loader.
//
// Signals:
//   Start    : pulse that begins a load session
//   ByteLen  : program length in bytes, sampled with an accepted Start
//   InValid  : InByte carries a valid byte
//   InByte   : program byte, big-endian stream order
//   InReady  : loader takes a byte this cycle
//   MemWE    : byte write strobe to the instruction memory
//   MemAddr  : byte write address
//   MemWData : byte write data
//   InsMemRW : fetch-read enable to the instruction memory (0 while loading)
//   Busy     : loader is in LOAD
//   Done     : loader is in DONE
//   Error    : sticky rejection / checksum error flag
//
// Modports:
//   master : host / stream source side (drives Start, ByteLen, InValid, InByte)
//   slave  : the loader itself
interface ins_mem_loader_if;
  logic        Start;
  logic [7:0]  ByteLen;
  logic        InValid;
  logic [7:0]  InByte;
  logic        InReady;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [7:0]  MemWData;
  logic        InsMemRW;
  logic        Busy;
  logic        Done;
  logic        Error;

  modport master (
    output Start, ByteLen, InValid, InByte,
    input  InReady, MemWE, MemAddr, MemWData, InsMemRW, Busy, Done, Error
  );

  modport slave (
    input  Start, ByteLen, InValid, InByte,
    output InReady, MemWE, MemAddr, MemWData, InsMemRW, Busy, Done, Error
  );
endinterface

// File: rtl/ins_mem_loader.sv
// ins_mem_loader -- streams a program, byte by byte, into the instruction
// memory and holds off instruction fetch while it does so.
//
// Parameters:
//   MEM_BYTES : instruction memory depth in bytes
//   BASE_ADDR : byte address of the first program byte
//
// Ports:
//   CLK       : clock, all state changes on the rising edge
//   Reset     : synchronous, active-high reset
//   bus       : ins_mem_loader_if.slave (stream handshake + memory write port)
//   dbg_state : current FSM state (0 IDLE, 1 LOAD, 2 DONE)
//
// Optional feature: define LOADER_CHECKSUM_EN to make the loader accept one
// extra byte after the program, compare it with the XOR of all program bytes,
// and raise Error on mismatch. The checksum byte is never written to memory.
//
// Handshake: a byte moves from the source to the loader on every rising edge
// where InValid && InReady. InReady depends only on loader state (never on
// InValid), the source may raise or drop InValid freely, and InValid is
// ignored whenever InReady is low.
module ins_mem_loader #(
  parameter int MEM_BYTES = 91,
  parameter int BASE_ADDR = 0
) (
  input  logic             CLK,
  input  logic             Reset,
  ins_mem_loader_if.slave  bus,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [31:0] MEM_BYTES_U = MEM_BYTES;
  localparam logic [31:0] BASE_ADDR_U = BASE_ADDR;

  logic [1:0]  state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  count_q, count_d;
  logic        error_q, error_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic        csum_phase_q, csum_phase_d;
  logic [7:0]  csum_q, csum_d;
  logic        csum_xfer;
`endif

  logic in_ready;
  logic xfer;
  logic prog_xfer;
  logic len_bad;
  logic last_byte;

  // A length is unusable if it is empty, larger than the memory, or not a
  // whole number of 32-bit instructions. This check is what keeps MemAddr
  // inside the memory.
  always_comb begin
    len_bad = (bus.ByteLen == 8'd0)
           || ({24'd0, bus.ByteLen} > MEM_BYTES_U)
           || (bus.ByteLen[1:0] != 2'b00);
  end

  always_comb begin
    in_ready  = (state_q == ST_LOAD);
    xfer      = bus.InValid && in_ready;
    last_byte = (count_q == (len_q - 8'd1));
`ifdef LOADER_CHECKSUM_EN
    prog_xfer = xfer && !csum_phase_q;
    csum_xfer = xfer && csum_phase_q;
`else
    prog_xfer = xfer;
`endif
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    error_d     = error_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_phase_d = csum_phase_q;
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          if (len_bad) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            error_d = 1'b0;
            len_d   = bus.ByteLen;
            count_d = 8'd0;
            state_d = ST_LOAD;
`ifdef LOADER_CHECKSUM_EN
            csum_phase_d = 1'b0;
            csum_d       = 8'd0;
`endif
          end
        end
      end

      ST_LOAD: begin
        // Start is deliberately not looked at here: a session runs to its end.
        if (prog_xfer) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR_U + {24'd0, count_q};
          mem_wdata_d = bus.InByte;
          count_d     = count_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.InByte;
          if (last_byte) begin
            csum_phase_d = 1'b1;
          end
`else
          if (last_byte) begin
            state_d = ST_DONE;
          end
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        if (csum_xfer) begin
          if (bus.InByte != csum_q) begin
            error_d = 1'b1;
          end
          csum_phase_d = 1'b0;
          state_d      = ST_DONE;
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      count_q     <= 8'd0;
      error_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_phase_q <= 1'b0;
      csum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      error_q     <= error_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_phase_q <= csum_phase_d;
      csum_q       <= csum_d;
`endif
    end
  end

  // The final write lands in the first DONE cycle, so fetch stays disabled
  // until that write strobe has dropped.
  always_comb begin
    bus.InReady  = in_ready;
    bus.MemWE    = mem_we_q;
    bus.MemAddr  = mem_addr_q;
    bus.MemWData = mem_wdata_q;
    bus.InsMemRW = !((state_q == ST_LOAD) || mem_we_q);
    bus.Busy     = (state_q == ST_LOAD);
    bus.Done     = (state_q == ST_DONE);
    bus.Error    = error_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
module tb_ins_mem_loader;

  localparam int MEM_BYTES = 91;
  localparam int BASE      = 0;

  logic       CLK;
  logic       Reset;
  logic [1:0] dbg_state;

  ins_mem_loader_if ifc ();

  ins_mem_loader #(
    .MEM_BYTES (MEM_BYTES),
    .BASE_ADDR (BASE)
  ) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .bus       (ifc.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- scoreboard ----------------
  int checks;
  int errors;
  int wr_cnt;
  logic [39:0] exp_q[$];   // {addr, data} of each expected memory write
  logic [40:0] obs_q[$];   // {InsMemRW, addr, data} of each observed write
  logic [7:0]  stream [0:255];
  bit          pat [7];

  typedef struct {
    logic [7:0] len;
    bit         exp_err;
    int         mode;
    bit         preset;
  } vec_t;
  vec_t vecs [12];

  always @(negedge CLK) begin
    if (ifc.MemWE) obs_q.push_back({ifc.InsMemRW, ifc.MemAddr, ifc.MemWData});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain();
    logic [40:0] o;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o[39:8], o[7:0]);
      end else begin
        check("mem_write", {24'd0, o[39:0]}, {24'd0, exp_q.pop_front()});
      end
      check("insmemrw_during_write", {63'd0, o[40]}, 64'd0);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic pulse_start(input logic [7:0] len);
    ifc.Start   = 1'b1;
    ifc.ByteLen = len;
    tick();
    ifc.Start   = 1'b0;
    ifc.ByteLen = 8'($urandom_range(0, 255));
  endtask

  // mode 0: InValid always high, 1: random gaps, 2: fixed pattern in pat[]
  task automatic send_bytes(input int first, input int n, input int mode);
    int i;
    int guard;
    int p;
    bit v;
    i = first;
    guard = 0;
    p = 0;
    while (i < first + n && guard < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: begin v = pat[p % 7]; p++; end
      endcase
      ifc.InValid = v;
      ifc.InByte  = v ? stream[i] : 8'($urandom_range(0, 255));
      @(negedge CLK);
      if (v && ifc.InReady) begin
        exp_q.push_back({32'(BASE + i), stream[i]});
        i++;
      end
      tick();
      guard++;
    end
    ifc.InValid = 1'b0;
    check("send_complete", 64'(i), 64'(first + n));
  endtask

  task automatic send_one(input logic [7:0] b);
    bit took;
    took = 1'b0;
    ifc.InValid = 1'b1;
    ifc.InByte  = b;
    for (int k = 0; k < 20 && !took; k++) begin
      @(negedge CLK);
      took = ifc.InReady;
      tick();
    end
    ifc.InValid = 1'b0;
    check("csum_accept", {63'd0, took}, 64'd1);
  endtask

  task automatic check_idle_after_reject();
    check("rej_error", {63'd0, ifc.Error}, 64'd1);
    check("rej_busy",  {63'd0, ifc.Busy},  64'd0);
    check("rej_done",  {63'd0, ifc.Done},  64'd0);
    check("rej_ready", {63'd0, ifc.InReady}, 64'd0);
    check("rej_state", {62'd0, dbg_state}, 64'd0);
  endtask

  task automatic check_done(input int base, input int n, input bit exp_err);
    tick();
    check("done_flag",  {63'd0, ifc.Done},     64'd1);
    check("done_error", {63'd0, ifc.Error},    64'({exp_err}));
    check("done_busy",  {63'd0, ifc.Busy},     64'd0);
    check("done_rw",    {63'd0, ifc.InsMemRW}, 64'd1);
    check("done_state", {62'd0, dbg_state},    64'd2);
    check("exp_q_empty", 64'(exp_q.size()),    64'd0);
    check("write_count", 64'(wr_cnt - base),   64'(n));
  endtask

  task automatic run_vec(input logic [7:0] len, input bit exp_err, input int mode, input bit preset);
    int base;
    logic [7:0] x;
    base = wr_cnt;
    x = 8'd0;
    for (int i = 0; i < int'(len); i++) begin
      if (!preset) stream[i] = 8'($urandom_range(0, 255));
      x = x ^ stream[i];
    end
    pulse_start(len);
    if (exp_err) begin
      check_idle_after_reject();
      tick();
      tick();
      check("rej_no_write", 64'(wr_cnt - base), 64'd0);
    end else begin
      check("load_busy",  {63'd0, ifc.Busy},     64'd1);
      check("load_ready", {63'd0, ifc.InReady},  64'd1);
      check("load_rw",    {63'd0, ifc.InsMemRW}, 64'd0);
      check("load_error", {63'd0, ifc.Error},    64'd0);
      send_bytes(0, int'(len), mode);
`ifdef LOADER_CHECKSUM_EN
      send_one(x);
`endif
      check_done(base, int'(len), 1'b0);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base;
    logic [7:0] x;
    checks = 0;
    errors = 0;
    wr_cnt = 0;
    Reset = 1'b1;
    ifc.Start = 1'b0;
    ifc.ByteLen = 8'd0;
    ifc.InValid = 1'b0;
    ifc.InByte = 8'd0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // len, exp_err, mode, preset stream
    vecs[0]  = '{8'd8,   1'b0, 0, 1'b1};
    vecs[1]  = '{8'd6,   1'b1, 0, 1'b0};
    vecs[2]  = '{8'd0,   1'b1, 0, 1'b0};
    vecs[3]  = '{8'd92,  1'b1, 0, 1'b0};
    vecs[4]  = '{8'd4,   1'b0, 1, 1'b0};
    vecs[5]  = '{8'd91,  1'b1, 0, 1'b0};
    vecs[6]  = '{8'd88,  1'b0, 1, 1'b0};
    vecs[7]  = '{8'd255, 1'b1, 0, 1'b0};
    vecs[8]  = '{8'd12,  1'b0, 0, 1'b0};
    vecs[9]  = '{8'd96,  1'b1, 0, 1'b0};
    vecs[10] = '{8'd2,   1'b1, 0, 1'b0};
    vecs[11] = '{8'd16,  1'b0, 1, 1'b0};

    // Reset state
    tick(); tick(); tick();
    check("rst_ready",  {63'd0, ifc.InReady},  64'd0);
    check("rst_we",     {63'd0, ifc.MemWE},    64'd0);
    check("rst_addr",   {32'd0, ifc.MemAddr},  64'd0);
    check("rst_wdata",  {56'd0, ifc.MemWData}, 64'd0);
    check("rst_busy",   {63'd0, ifc.Busy},     64'd0);
    check("rst_done",   {63'd0, ifc.Done},     64'd0);
    check("rst_error",  {63'd0, ifc.Error},    64'd0);
    check("rst_rw",     {63'd0, ifc.InsMemRW}, 64'd1);
    Reset = 1'b0;
    tick();

    // Table: first entry is the reference program 08 01 00 08 48 02 00 02
    stream[0] = 8'h08; stream[1] = 8'h01; stream[2] = 8'h00; stream[3] = 8'h08;
    stream[4] = 8'h48; stream[5] = 8'h02; stream[6] = 8'h00; stream[7] = 8'h02;
    for (int v = 0; v < 12; v++) begin
      run_vec(vecs[v].len, vecs[v].exp_err, vecs[v].mode, vecs[v].preset);
    end

    // Gappy InValid pattern 1,0,0,1,1,0,1 on a 4-byte program
    base = wr_cnt;
    x = 8'd0;
    for (int i = 0; i < 4; i++) begin
      stream[i] = 8'($urandom_range(0, 255));
      x = x ^ stream[i];
    end
    pulse_start(8'd4);
    send_bytes(0, 4, 2);
`ifdef LOADER_CHECKSUM_EN
    send_one(x);
`endif
    check_done(base, 4, 1'b0);

    // InValid while in DONE must be ignored
    base = wr_cnt;
    ifc.InValid = 1'b1;
    ifc.InByte = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("done_not_ready", {63'd0, ifc.InReady}, 64'd0);
    end
    ifc.InValid = 1'b0;
    tick();
    check("done_ignore_wr", 64'(wr_cnt - base), 64'd0);
    check("done_hold", {63'd0, ifc.Done}, 64'd1);

    // Start during LOAD is ignored: the 8-byte session continues at address 3
    base = wr_cnt;
    x = 8'd0;
    for (int i = 0; i < 8; i++) begin
      stream[i] = 8'($urandom_range(0, 255));
      x = x ^ stream[i];
    end
    pulse_start(8'd8);
    send_bytes(0, 3, 0);
    pulse_start(8'd4);
    check("ignore_start_busy", {63'd0, ifc.Busy}, 64'd1);
    send_bytes(3, 5, 1);
`ifdef LOADER_CHECKSUM_EN
    send_one(x);
`endif
    check_done(base, 8, 1'b0);

    // Reset after 2 of 8 bytes, with Start and InValid also asserted
    for (int i = 0; i < 8; i++) stream[i] = 8'($urandom_range(0, 255));
    pulse_start(8'd8);
    send_bytes(0, 2, 0);
    Reset = 1'b1;
    ifc.Start = 1'b1;
    ifc.ByteLen = 8'd8;
    ifc.InValid = 1'b1;
    ifc.InByte = 8'h5A;
    tick();
    check("mid_rst_ready", {63'd0, ifc.InReady},  64'd0);
    check("mid_rst_we",    {63'd0, ifc.MemWE},    64'd0);
    check("mid_rst_addr",  {32'd0, ifc.MemAddr},  64'd0);
    check("mid_rst_wdata", {56'd0, ifc.MemWData}, 64'd0);
    check("mid_rst_busy",  {63'd0, ifc.Busy},     64'd0);
    check("mid_rst_done",  {63'd0, ifc.Done},     64'd0);
    check("mid_rst_error", {63'd0, ifc.Error},    64'd0);
    check("mid_rst_rw",    {63'd0, ifc.InsMemRW}, 64'd1);
    check("mid_rst_state", {62'd0, dbg_state},    64'd0);
    Reset = 1'b0;
    ifc.Start = 1'b0;
    ifc.InValid = 1'b0;
    tick();
    check("post_rst_we", {63'd0, ifc.MemWE}, 64'd0);
    check("post_rst_q",  64'(exp_q.size()),  64'd0);
    run_vec(8'd8, 1'b0, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // Checksum match and mismatch on FC 00 00 00
    stream[0] = 8'hFC; stream[1] = 8'h00; stream[2] = 8'h00; stream[3] = 8'h00;
    base = wr_cnt;
    pulse_start(8'd4);
    send_bytes(0, 4, 0);
    check("csum_pending_busy", {63'd0, ifc.Busy}, 64'd1);
    send_one(8'hFC);
    check_done(base, 4, 1'b0);
    base = wr_cnt;
    pulse_start(8'd4);
    send_bytes(0, 4, 1);
    send_one(8'h00);
    check_done(base, 4, 1'b1);
`endif

    tick();
    tick();
    check("final_exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
